stopwatch_timebase: RTL and testbench
=====================================

// Module: stopwatch_timebase
// PURPOSE
//  Timekeeping core of the stopwatch: divides the system clock to a 1 Hz tick and counts MM:SS in binary.
//  Sits directly upstream of the seven-segment display driver; minutes/seconds feed its minutes/seconds inputs.
//  Takes single-cycle, already-debounced button pulses: start/stop, clear, lap.
//  Provides a lap-hold freeze of the displayed value while timing continues internally.
// PARAMETERS
//  TICK_DIV     100_000_000  clock cycles per counted second; must be >= 2
//  MAX_MINUTES  99           highest minute value; count saturates at MAX_MINUTES:59
// PORTS
//  clock       in   1  system clock, single clock domain
//  reset       in   1  asynchronous, active-high; clears all state
//  start_stop  in   1  one-cycle pulse; toggles run/pause
//  clear       in   1  one-cycle pulse; returns to 00:00, idle
//  lap         in   1  one-cycle pulse; toggles lap hold of the displayed value
//  minutes     out  7  displayed minutes, 0..MAX_MINUTES, registered
//  seconds     out  7  displayed seconds, 0..59, registered
//  running     out  1  1 while in RUN
//  lap_active  out  1  1 while the displayed value is frozen
//  overflow    out  1  sticky; 1 once the count saturated
// BEHAVIOUR
//  Reset: state=IDLE, prescaler=0, count=00:00, minutes=0, seconds=0, running=0, lap_active=0, overflow=0.
//  States:
//   IDLE  --start_stop--> RUN
//   RUN   --start_stop--> PAUSE
//   RUN   --saturate--> DONE
//   PAUSE --start_stop--> RUN
//   any   --clear--> IDLE
//   DONE ignores start_stop; only clear or reset leaves it.
//  Prescaler:
//   Counts 0..TICK_DIV-1 only in RUN; tick = (prescaler==TICK_DIV-1) in RUN.
//   On tick the prescaler wraps to 0.
//   Holds its value in PAUSE, so the sub-second fraction is preserved across pause/resume.
//   Zeroed in IDLE and DONE.
//  Count on tick:
//   sec<59: sec+1.
//   sec==59 and min<MAX_MINUTES: sec=0, min+1.
//   At MAX_MINUTES:59 the tick does not change the count; it sets overflow=1 and enters DONE.
//  Widths: sec and min are 7-bit unsigned binary, never BCD; values outside the stated ranges never appear.
//  Latency:
//   Count registers update on the clock edge that ends the tick cycle.
//   minutes/seconds show the new value in the same cycle when lap_active=0 (registered outputs, no extra stage).
//  Lap:
//   In RUN, lap with lap_active=0 snapshots the current count into the outputs and sets lap_active=1.
//   The internal count continues.
//   lap with lap_active=1 (any state) clears lap_active; outputs track the live count from the next cycle.
//   lap in IDLE/PAUSE/DONE with lap_active=0 is ignored.
//  Priority within one cycle: clear > start_stop > lap.
//   Clear discards a coincident start_stop/lap and zeroes prescaler, count, lap_active and overflow.
//   Lap coincident with start_stop is ignored.
//  Tick coincident with start_stop in RUN: the tick is counted, then the state becomes PAUSE.
//  Asynchronous reset mid-count returns every register to its reset value immediately; no partial update.
//  running = (state==RUN); it is registered and follows the state in the same cycle.
// STRUCTURE
//  Shared include stopwatch_defs.vh:
//   state encodings IDLE/RUN/PAUSE/DONE (2 bits)
//   SEC_MAX=59
//   COUNT_W=7
//  Sub-module tick_prescaler: ports clock, reset, enable, clear, tick; parameter TICK_DIV.
//   Hold while enable=0, zero on clear.
//  The state machine, MM:SS counter and lap snapshot register live in stopwatch_timebase.
// TESTING (sim with TICK_DIV=4, MAX_MINUTES=2)
//  1. Reset, start_stop, run 8 cycles
//     -> seconds=2, minutes=0, running=1; first increment 4 cycles after RUN entry.
//  2. Run to 00:59, one more tick -> 01:00 in the same cycle the prescaler wraps.
//     Continue to 02:59, one more tick -> count holds 02:59, overflow=1, running=0;
//     start_stop then ignored; clear -> 00:00, overflow=0.
//  3. Pause 2 cycles into a second, wait 20 cycles, resume
//     -> next increment exactly 2 cycles after resume; count unchanged while paused.
//  4. Lap at 00:03, run 3 more seconds -> outputs stay 00:03, lap_active=1.
//     Lap again -> outputs 00:06 next cycle.
//  5. Same-cycle tests:
//     start_stop+clear in RUN -> IDLE, 00:00.
//     start_stop on a tick cycle at 00:04 -> 00:05, PAUSE.
//     lap+start_stop -> lap ignored.
//  6. Assert reset asynchronously mid-second at 01:30 -> all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/stopwatch_timebase_pkg.sv
// Shared definitions for the stopwatch timebase: state encoding and count geometry.
package stopwatch_timebase_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } sw_state_e;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned COUNT_W = 7;

endpackage

// File: rtl/stopwatch_timebase_tick_prescaler.sv
// Divides the system clock down to a one-cycle tick every TICK_DIV enabled cycles.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == CW'(TICK_DIV - 1));

  // Holding while disabled keeps the sub-second fraction across a pause.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/stopwatch_timebase.sv
// Stopwatch timekeeping core: run/pause/done control, binary MM:SS counter and lap hold.
module stopwatch_timebase
  import stopwatch_timebase_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 100_000_000,
  parameter int unsigned MAX_MINUTES = 99
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_stop,
  input  logic               clear,
  input  logic               lap,
  output logic [COUNT_W-1:0] minutes,
  output logic [COUNT_W-1:0] seconds,
  output logic               running,
  output logic               lap_active,
  output logic               overflow
);

  sw_state_e          state, state_nx;
  logic [COUNT_W-1:0] sec_q, min_q, sec_nx, min_nx;
  logic [COUNT_W-1:0] min_out_nx, sec_out_nx;
  logic               lap_nx, ovf_nx;
  logic               tick, at_max, presc_en, presc_clr;

  assign presc_en  = (state == ST_RUN);
  assign presc_clr = clear || (state == ST_IDLE) || (state == ST_DONE);
  assign at_max    = (sec_q == COUNT_W'(SEC_MAX)) && (min_q == COUNT_W'(MAX_MINUTES));

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .enable(presc_en),
    .clear (presc_clr),
    .tick  (tick)
  );

  always_comb begin
    state_nx   = state;
    sec_nx     = sec_q;
    min_nx     = min_q;
    lap_nx     = lap_active;
    ovf_nx     = overflow;
    min_out_nx = minutes;
    sec_out_nx = seconds;

    if (clear) begin
      state_nx = ST_IDLE;
      sec_nx   = '0;
      min_nx   = '0;
      lap_nx   = 1'b0;
      ovf_nx   = 1'b0;
    end else begin
      if (tick) begin
        if (at_max) begin
          ovf_nx   = 1'b1;
          state_nx = ST_DONE;
        end else if (sec_q == COUNT_W'(SEC_MAX)) begin
          sec_nx = '0;
          min_nx = min_q + COUNT_W'(1);
        end else begin
          sec_nx = sec_q + COUNT_W'(1);
        end
      end

      // A saturating tick wins over a coincident start_stop: the count is finished.
      if (start_stop) begin
        unique case (state)
          ST_IDLE:  state_nx = ST_RUN;
          ST_RUN:   if (!(tick && at_max)) state_nx = ST_PAUSE;
          ST_PAUSE: state_nx = ST_RUN;
          default:  ;
        endcase
      end else if (lap) begin
        if (lap_active) begin
          lap_nx = 1'b0;
        end else if (state == ST_RUN) begin
          lap_nx = 1'b1;
        end
      end
    end

    // Freezing just holds the output registers, which already show the pre-edge count.
    if (!lap_nx) begin
      min_out_nx = min_nx;
      sec_out_nx = sec_nx;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      sec_q      <= '0;
      min_q      <= '0;
      minutes    <= '0;
      seconds    <= '0;
      running    <= 1'b0;
      lap_active <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nx;
      sec_q      <= sec_nx;
      min_q      <= min_nx;
      minutes    <= min_out_nx;
      seconds    <= sec_out_nx;
      running    <= (state_nx == ST_RUN);
      lap_active <= lap_nx;
      overflow   <= ovf_nx;
    end
  end

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Scoreboard bench: model predicts display per cycle from elapsed run time, monitor compares.
module tb_stopwatch_timebase;

  localparam int unsigned DIV  = 4;
  localparam int unsigned MAXM = 2;
  localparam int unsigned CAP  = MAXM * 60 + 59;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic [6:0] minutes, seconds;
  logic       running, lap_active, overflow;

  stopwatch_timebase #(
    .TICK_DIV   (DIV),
    .MAX_MINUTES(MAXM)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start_stop(start_stop),
    .clear     (clear),
    .lap       (lap),
    .minutes   (minutes),
    .seconds   (seconds),
    .running   (running),
    .lap_active(lap_active),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned m;
    int unsigned s;
    bit          run;
    bit          lapa;
    bit          ovf;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference: elapsed RUN cycles since clear; displayed seconds = r / DIV.
  int          mst = M_IDLE;
  int unsigned r = 0;
  bit          m_lap = 0;
  bit          m_ovf = 0;
  int unsigned frozen = 0;

  task automatic model_step(input bit ss, input bit clr, input bit lp);
    int unsigned pre_sec;
    int          pre_state;
    bit          sat;
    exp_t        e;
    pre_sec   = r / DIV;
    pre_state = mst;
    sat       = 0;
    if (clr) begin
      mst = M_IDLE; r = 0; m_lap = 0; m_ovf = 0;
    end else begin
      if (mst == M_RUN) begin
        if (((r + 1) % DIV == 0) && pre_sec == CAP) begin
          sat = 1; m_ovf = 1; r = CAP * DIV; mst = M_DONE;
        end else begin
          r++;
        end
      end
      if (ss) begin
        if (!sat) begin
          case (pre_state)
            M_IDLE:  mst = M_RUN;
            M_RUN:   mst = M_PAUSE;
            M_PAUSE: mst = M_RUN;
            default: ;
          endcase
        end
      end else if (lp) begin
        if (m_lap) m_lap = 0;
        else if (pre_state == M_RUN) begin
          m_lap = 1; frozen = pre_sec;
        end
      end
    end
    e.m    = (m_lap ? frozen : r / DIV) / 60;
    e.s    = (m_lap ? frozen : r / DIV) % 60;
    e.run  = (mst == M_RUN);
    e.lapa = m_lap;
    e.ovf  = m_ovf;
    sb.push_back(e);
  endtask

  task automatic step(input bit ss, input bit clr, input bit lp);
    @(negedge clock);
    start_stop = ss;
    clear      = clr;
    lap        = lp;
    model_step(ss, clr, lp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (!reset && sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if ({minutes, seconds, running, lap_active, overflow} !==
            {7'(e.m), 7'(e.s), e.run, e.lapa, e.ovf}) begin
          miscompares++;
          $display("FAIL cycle_vec%0d: got %0d:%0d run=%b lap=%b ovf=%b, expected %0d:%0d run=%b lap=%b ovf=%b",
                   vectors, minutes, seconds, running, lap_active, overflow,
                   e.m, e.s, e.run, e.lapa, e.ovf);
        end
      end
    end
  end

  task automatic check_zero(input string name);
    vectors++;
    if ({minutes, seconds, running, lap_active, overflow} !== '0) begin
      miscompares++;
      $display("FAIL %s: got %0d:%0d run=%b lap=%b ovf=%b, expected 0:0 run=0 lap=0 ovf=0",
               name, minutes, seconds, running, lap_active, overflow);
    end
  endtask

  initial begin : driver
    int waitn;
    repeat (2) @(negedge clock);
    #1;
    check_zero("reset_state");
    @(negedge clock);
    reset = 1'b0;

    // Start, eight cycles of running
    step(1, 0, 0); idle(8);

    // Full run to saturation, ignored start_stop, then clear
    step(0, 1, 0); step(1, 0, 0);
    idle(CAP * DIV + DIV + 2);
    step(1, 0, 0); idle(3);
    step(0, 1, 0); idle(2);

    // Pause mid-second and resume
    step(1, 0, 0); idle(DIV + 1);
    step(1, 0, 0); idle(20);
    step(1, 0, 0); idle(DIV + 2);

    // Lap hold at 00:03 while counting continues
    step(0, 1, 0); step(1, 0, 0); idle(3 * DIV);
    step(0, 0, 1); idle(3 * DIV);
    step(0, 0, 1); idle(2);

    // Same-cycle priority cases
    step(0, 1, 0); step(1, 0, 0); idle(3);
    step(1, 1, 0); idle(2);
    step(1, 0, 0); idle(5 * DIV - 1);
    step(1, 0, 0); idle(2);
    step(1, 0, 1); idle(3);

    // Run to 01:30 plus part of a second, then asynchronous reset
    step(0, 1, 0); step(1, 0, 0); idle(90 * DIV + 2);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    sb.delete();
    mst = M_IDLE; r = 0; m_lap = 0; m_ovf = 0;
    start_stop = 0; clear = 0; lap = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Randomized control pulses
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(19) == 0, $urandom_range(199) == 0, $urandom_range(14) == 0);
    end
    idle(2);

    waitn = 0;
    while (sb.size() > 0 && waitn < 10) begin
      @(posedge clock);
      waitn++;
    end
    #2;
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
